// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//  Shared types and helpers for the FIFO write-port arbiter.
//  - arb_state_e : arbiter state (IDLE = port free, BURST = an owner holds the port)
//  - rr_pick_t   : result of a round-robin scan (found flag + winning index)
//  - rr_first()  : first set request scanning start, start+1, ... wrapping at n_req
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // The scan helper works on a fixed-width request vector so it can be shared
    // by any arbiter size up to RR_MAX_REQ requesters.
    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Returns the first set bit of req[n_req-1:0] met when scanning upward from
    // start and wrapping from n_req-1 back to 0. start must be < n_req.
    function automatic rr_pick_t rr_first(
        input logic [RR_MAX_REQ-1:0] req,
        input int                    n_req,
        input int                    start
    );
        rr_pick_t pick;
        int       j;
        pick = '0;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            j = start + k;
            if (j >= n_req) begin
                j = j - n_req;
            end
            if ((k < n_req) && !pick.found && req[j[RR_IDX_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = j[RR_IDX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// fifo_rr_picker
//  Combinational round-robin picker. Masks out the excluded requesters, then
//  returns the first remaining request found scanning from start upward with
//  wrap-around.
// Ports
//  req     in  N_REQ   request vector
//  start   in  IDX_W   index where the scan begins
//  exclude in  N_REQ   requesters that may not win this scan
//  onehot  out N_REQ   one-hot winner (all zero when nothing found)
//  idx     out IDX_W   winner index (only meaningful when found)
//  found   out 1       a winner exists
module fifo_rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    input  logic [N_REQ-1:0] exclude,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [RR_MAX_REQ-1:0] req_ext;
    rr_pick_t              pick;

    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req & ~exclude;
    end

    assign pick  = rr_first(req_ext, N_REQ, int'(start));
    assign found = pick.found;
    assign idx   = pick.idx[IDX_W-1:0];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign onehot[gi] = pick.found && (pick.idx == RR_IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//  Sole writer of a synchronous FIFO, shared by N_REQ producers. Round-robin
//  arbitration with bounded bursts: the winner keeps the port for up to
//  MAX_BURST consecutive beats, then must rotate if anyone else is waiting.
//  The FIFO full flag gates every grant and freezes all arbiter state.
// Ports
//  clk         in  1            clock, rising edge
//  reset       in  1            asynchronous active-low reset
//  req         in  N_REQ        per-requester valid, held with req_data until granted
//  req_data    in  N_REQ*WIDTH  packed data, slice i = [i*WIDTH +: WIDTH]
//  gnt         out N_REQ        one-hot accept (combinational); beat moves at posedge
//  fifo_full   in  1            FIFO full flag
//  fifo_w_enb  out 1            FIFO write enable (= |gnt)
//  fifo_d_in   out WIDTH        data of the granted requester, 0 with no grant
//  owner       out clog2(N_REQ) current burst owner (registered)
//  busy        out 1            high while a burst is in progress
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int WIDTH     = 32,
    parameter  int MAX_BURST = 4,
    localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    input  logic                   fifo_full,
    output logic                   fifo_w_enb,
    output logic [WIDTH-1:0]       fifo_d_in,
    output logic [IDX_W-1:0]       owner,
    output logic                   busy
);

    arb_state_e       state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;

    logic [N_REQ-1:0] owner_onehot;
    logic [IDX_W-1:0] owner_plus1;
    logic             owner_req;
    logic             owner_can_continue;

    logic [IDX_W-1:0] pick_start;
    logic [N_REQ-1:0] pick_exclude;
    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    logic [N_REQ-1:0] gnt_comb;
    logic [WIDTH-1:0] slice_masked [N_REQ];

    // ------------------------------------------------------------------
    // Owner decode and eligibility
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_owner_dec
            assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
        end
    endgenerate

    assign owner_plus1 = (owner_reg == IDX_W'(N_REQ - 1)) ? '0 : owner_reg + IDX_W'(1);
    assign owner_req   = |(req & owner_onehot);

    // The owner may keep the port only while it still has data and has not
    // used up its burst allowance.
    assign owner_can_continue = (state_reg == BURST) && owner_req &&
                                (burst_cnt_reg < CNT_W'(MAX_BURST));

    // ------------------------------------------------------------------
    // Single shared picker: from IDLE it scans from ptr over everyone; on a
    // burst release it scans from owner+1 with the old owner excluded, so the
    // owner only re-wins when nobody else is asking.
    // ------------------------------------------------------------------
    assign pick_start   = (state_reg == BURST) ? owner_plus1  : ptr_reg;
    assign pick_exclude = (state_reg == BURST) ? owner_onehot : '0;

    fifo_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (req),
        .start   (pick_start),
        .exclude (pick_exclude),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    // ------------------------------------------------------------------
    // Next-state and grant logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        gnt_comb       = '0;

        // A full FIFO freezes everything, including an ongoing burst.
        if (!fifo_full) begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        gnt_comb       = pick_onehot;
                        state_next     = BURST;
                        owner_next     = pick_idx;
                        burst_cnt_next = CNT_W'(1);
                    end
                end

                BURST: begin
                    if (owner_can_continue) begin
                        gnt_comb       = owner_onehot;
                        // Never exceeds MAX_BURST: eligibility requires cnt < MAX_BURST.
                        burst_cnt_next = burst_cnt_reg + CNT_W'(1);
                    end else begin
                        // Release this cycle and hand over without a bubble.
                        ptr_next = owner_plus1;
                        if (pick_found) begin
                            gnt_comb       = pick_onehot;
                            owner_next     = pick_idx;
                            burst_cnt_next = CNT_W'(1);
                        end else if (owner_req) begin
                            gnt_comb       = owner_onehot;
                            burst_cnt_next = CNT_W'(1);
                        end else begin
                            state_next     = IDLE;
                            burst_cnt_next = '0;
                        end
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Grants are blanked while reset is asserted so an in-flight
    // beat is dropped rather than written.
    // ------------------------------------------------------------------
    assign gnt        = reset ? gnt_comb : '0;
    assign fifo_w_enb = |gnt;
    assign owner      = owner_reg;
    assign busy       = (state_reg == BURST);

    // AND-OR data mux: at most one gnt bit is set, so OR-ing masked slices
    // selects the granted slice and yields zero when nothing is granted.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data_mask
            assign slice_masked[gi] = gnt[gi] ? req_data[gi*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        fifo_d_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            fifo_d_in = fifo_d_in | slice_masked[i];
        end
    end

endmodule
